dcache_nb: RTL
==============

Name: dcache_nb

Overview:
- Parametrised non-blocking, direct-mapped, write-through data cache with N_LD load ports, one store port and N_MSHR miss-status entries.
- Sits between the load/store units and the tagged single-port memory (BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2).
- Hits return in the same cycle. Misses to the same line merge into one MSHR. Fills are forwarded to every waiting port.

Parameters:
- N_LD, 2, number of load ports
- N_MSHR, 4, outstanding line misses (≤15)
- N_LINES, 32, cache lines (power of 2); line = 8 bytes
- ADDR_W, 32, byte address width

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem2dc_response  in  4  nonzero = request accepted; value is the transaction tag
- mem2dc_data  in  64  fill data
- mem2dc_tag  in  4  nonzero = fill for that tag this cycle
- ld_addr  in  N_LD×ADDR_W  load byte addresses
- ld_en  in  N_LD  load requests
- st_addr  in  ADDR_W  store address
- st_data  in  64  store doubleword
- st_en  in  1  store request
- dc2mem_command  out  2  bus command
- dc2mem_addr  out  ADDR_W  bus address, 8-byte aligned
- dc2mem_data  out  64  store data
- ld_data_out  out  N_LD×64  load data
- ld_valid_out  out  N_LD  data valid
- ld_accepted  out  N_LD  load taken (hit, new miss, or merged miss)
- st_accepted  out  1  store completed to memory

Behaviour:
- Address split: offset [2:0] ignored; index = next log2(N_LINES) bits; tag = remaining bits. Loads return the full 64-bit doubleword.
- Reset: all lines invalid, all MSHRs INVALID, no port waiting. All outputs 0 (command BUS_NONE).
- Load hit (combinational): ld_en[i] and line valid with matching tag → ld_valid_out[i]=ld_accepted[i]=1 and ld_data_out[i]=line data, same cycle.
- Load miss:
  - If a free MSHR exists, the lowest free entry is allocated and ld_accepted[i]=1. The port is marked waiting in that entry's waiter mask.
  - Multiple ports missing to the same new line in one cycle share one entry.
  - Allocation is in port order; ports with no free entry get ld_accepted=0 and retry.
  - A port already waiting is not accepted again until its data returns.
- MSHR states:
  - INVALID→PENDING on allocate.
  - PENDING→WAIT when its BUS_LOAD receives nonzero response; the tag is stored.
  - WAIT→INVALID when mem2dc_tag equals the stored tag. In that cycle the line is written at posedge and every waiter j gets ld_valid_out[j]=1 with ld_data_out[j]=mem2dc_data.
  - A new ld_en hit to the line being filled that cycle is served from mem2dc_data.
  - Fill and a hit on another port in the same cycle are both delivered.
- Bus arbitration, one request per cycle:
  - A pending store goes first, unless blocked.
  - Otherwise the lowest-index PENDING MSHR issues.
  - Requests are held until response is nonzero.
- Store (write-through, no-write-allocate):
  - Drives BUS_STORE with st_addr and st_data.
  - st_accepted=1 in the cycle response is nonzero; on that posedge, a resident matching line is updated.
  - If st_addr's line matches any valid MSHR, the store is blocked (no command, st_accepted=0) until the fill retires, so the fill never overwrites newer data.
- Fill returning with a tag matching no WAIT entry (e.g. after reset) is ignored.
- Reset asserted mid-miss: all state cleared next edge; outstanding waiters get no valid pulse.

Optional Feature:
- Macro DCACHE_MSHR_MERGE_EN.
- Defined: a miss whose line matches an existing PENDING/WAIT entry joins that entry's waiter mask, with no new bus request.
- Undefined: such a miss is rejected (ld_accepted=0) until that entry retires, then re-misses or hits. Same-cycle same-line misses still share one entry.

Test Plan:
- memory[i]=i (64-bit words). Port0 load 0x10 cold → accepted cycle 0, one BUS_LOAD 0x10, ld_valid_out[0] on fill with data 2. Reload 0x10 → same-cycle hit, data 2.
- Ports 0 and 1 both load 0x8 in the same cycle → exactly one BUS_LOAD. Both ld_valid_out assert in the same cycle, data 1.
- Line 0x8 resident; store 0x8 data 24 → BUS_STORE 0x8/24, st_accepted pulses. Port0 load 0x8 → 0-cycle hit, data 24.
- N_MSHR=2: misses 0x10, 0x20, then 0x30 → third ld_accepted=0 until the first fill retires, then accepted. All three return 2, 4, 6.
- Store 0x18 data 99 while 0x18 miss in WAIT → st_accepted held 0 until fill. The store then issues; a subsequent load of 0x18 returns 99.
- Reset during WAIT for 0x28 → outputs 0. The late fill tag is ignored, with no ld_valid_out pulse and the line still invalid.

Source files
------------

// File: rtl/dcache_nb.sv
// Non-blocking, direct-mapped, write-through data cache with MSHR-tracked misses and fill forwarding.
// Optional: define DCACHE_MSHR_MERGE_EN to let misses join an already outstanding entry for the same line.
module dcache_nb #(
  parameter int N_LD    = 2,
  parameter int N_MSHR  = 4,
  parameter int N_LINES = 32,
  parameter int ADDR_W  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             mem2dc_response,
  input  logic [63:0]            mem2dc_data,
  input  logic [3:0]             mem2dc_tag,
  input  logic [N_LD*ADDR_W-1:0] ld_addr,
  input  logic [N_LD-1:0]        ld_en,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [63:0]            st_data,
  input  logic                   st_en,
  output logic [1:0]             dc2mem_command,
  output logic [ADDR_W-1:0]      dc2mem_addr,
  output logic [63:0]            dc2mem_data,
  output logic [N_LD*64-1:0]     ld_data_out,
  output logic [N_LD-1:0]        ld_valid_out,
  output logic [N_LD-1:0]        ld_accepted,
  output logic                   st_accepted
);
  localparam int IDX_W  = $clog2(N_LINES);
  localparam int LINE_W = ADDR_W - 3;
  localparam int TAG_W  = LINE_W - IDX_W;
  localparam int MI_W   = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {MS_INVALID = 2'd0, MS_PENDING = 2'd1, MS_WAIT = 2'd2} ms_state_e;

  logic              line_valid_q [N_LINES];
  logic [TAG_W-1:0]  line_tag_q   [N_LINES];
  logic [63:0]       line_data_q  [N_LINES];

  ms_state_e         ms_state_q [N_MSHR];
  ms_state_e         ms_state_d [N_MSHR];
  logic [LINE_W-1:0] ms_line_q  [N_MSHR];
  logic [LINE_W-1:0] ms_line_d  [N_MSHR];
  logic [3:0]        ms_btag_q  [N_MSHR];
  logic [3:0]        ms_btag_d  [N_MSHR];
  logic [N_LD-1:0]   ms_wait_q  [N_MSHR];
  logic [N_LD-1:0]   ms_wait_d  [N_MSHR];

  logic              fill_v_s;
  logic [MI_W-1:0]   fill_idx_s;
  logic [LINE_W-1:0] fill_line_s;
  logic [N_LD-1:0]   fill_wait_s;
  logic              st_block_s;
  logic              st_go_s;
  logic              st_upd_s;
  logic              ld_go_s;
  logic [MI_W-1:0]   ld_go_idx_s;

  logic [N_MSHR-1:0] ms_new_s;
  logic [LINE_W-1:0] ms_new_line_s [N_MSHR];
  logic [N_LD-1:0]   ms_add_s      [N_MSHR];
  logic [N_LD-1:0]   ld_valid_s;
  logic [N_LD-1:0]   ld_acc_s;
  logic [63:0]       ld_rdata_s    [N_LD];
  logic [LINE_W-1:0] pl_s;
  logic              busy_s;
  logic              placed_s;
  logic              hit_s;
  logic              unused_s;

  // Identify the WAIT entry (if any) whose bus tag matches the returning fill.
  always_comb begin
    fill_v_s   = 1'b0;
    fill_idx_s = '0;
    for (int m = 0; m < N_MSHR; m++) begin
      if (!fill_v_s && (mem2dc_tag != 4'd0) && (ms_state_q[m] == MS_WAIT) && (ms_btag_q[m] == mem2dc_tag)) begin
        fill_v_s   = 1'b1;
        fill_idx_s = MI_W'(m);
      end else begin
        fill_v_s   = fill_v_s;
      end
    end
    fill_line_s = ms_line_q[fill_idx_s];
    fill_wait_s = fill_v_s ? ms_wait_q[fill_idx_s] : '0;
  end

  // Bus arbitration: an unblocked store wins, else the lowest PENDING entry.
  always_comb begin
    st_block_s  = 1'b0;
    ld_go_s     = 1'b0;
    ld_go_idx_s = '0;
    for (int m = 0; m < N_MSHR; m++) begin
      st_block_s = st_block_s | ((ms_state_q[m] != MS_INVALID) && (ms_line_q[m] == st_addr[ADDR_W-1:3]));
    end
    st_go_s  = st_en && !st_block_s;
    st_upd_s = st_go_s && (mem2dc_response != 4'd0) && line_valid_q[st_addr[IDX_W+2:3]]
               && (line_tag_q[st_addr[IDX_W+2:3]] == st_addr[ADDR_W-1:IDX_W+3]);
    for (int m = 0; m < N_MSHR; m++) begin
      if (!st_go_s && !ld_go_s && (ms_state_q[m] == MS_PENDING)) begin
        ld_go_s     = 1'b1;
        ld_go_idx_s = MI_W'(m);
      end else begin
        ld_go_s     = ld_go_s;
      end
    end
  end

  // Per-port hit / fill-forward / miss allocation, evaluated in port order.
  always_comb begin
    ms_new_s   = '0;
    ld_valid_s = '0;
    ld_acc_s   = '0;
    pl_s       = '0;
    busy_s     = 1'b0;
    placed_s   = 1'b0;
    hit_s      = 1'b0;
    for (int m = 0; m < N_MSHR; m++) begin
      ms_new_line_s[m] = '0;
      ms_add_s[m]      = '0;
    end
    for (int i = 0; i < N_LD; i++) begin
      ld_rdata_s[i] = 64'd0;
      pl_s     = ld_addr[i*ADDR_W+3 +: LINE_W];
      busy_s   = 1'b0;
      placed_s = 1'b0;
      for (int m = 0; m < N_MSHR; m++) begin
        busy_s = busy_s | ((ms_state_q[m] != MS_INVALID) && ms_wait_q[m][i]);
      end
      hit_s = line_valid_q[pl_s[IDX_W-1:0]] && (line_tag_q[pl_s[IDX_W-1:0]] == pl_s[LINE_W-1:IDX_W]);
      if (fill_wait_s[i]) begin
        ld_valid_s[i] = 1'b1;
        ld_rdata_s[i] = mem2dc_data;
      end else if (ld_en[i] && !busy_s && fill_v_s && (fill_line_s == pl_s)) begin
        ld_valid_s[i] = 1'b1;
        ld_acc_s[i]   = 1'b1;
        ld_rdata_s[i] = mem2dc_data;
      end else if (ld_en[i] && !busy_s && hit_s) begin
        ld_valid_s[i] = 1'b1;
        ld_acc_s[i]   = 1'b1;
        ld_rdata_s[i] = line_data_q[pl_s[IDX_W-1:0]];
      end else if (ld_en[i] && !busy_s) begin
        for (int m = 0; m < N_MSHR; m++) begin
          if (!placed_s && (ms_state_q[m] != MS_INVALID) && (ms_line_q[m] == pl_s)) begin
            placed_s = 1'b1;
`ifdef DCACHE_MSHR_MERGE_EN
            ms_add_s[m][i] = 1'b1;
            ld_acc_s[i]    = 1'b1;
`endif
          end else begin
            placed_s = placed_s;
          end
        end
        for (int m = 0; m < N_MSHR; m++) begin
          if (!placed_s && ms_new_s[m] && (ms_new_line_s[m] == pl_s)) begin
            placed_s       = 1'b1;
            ms_add_s[m][i] = 1'b1;
            ld_acc_s[i]    = 1'b1;
          end else begin
            placed_s = placed_s;
          end
        end
        for (int m = 0; m < N_MSHR; m++) begin
          if (!placed_s && !ms_new_s[m] && (ms_state_q[m] == MS_INVALID)) begin
            placed_s         = 1'b1;
            ms_new_s[m]      = 1'b1;
            ms_new_line_s[m] = pl_s;
            ms_add_s[m][i]   = 1'b1;
            ld_acc_s[i]      = 1'b1;
          end else begin
            placed_s = placed_s;
          end
        end
      end else begin
        ld_valid_s[i] = 1'b0;
      end
    end
  end

  // MSHR state register.
  always_ff @(posedge clock) begin
    for (int m = 0; m < N_MSHR; m++) begin
      if (reset) begin
        ms_state_q[m] <= MS_INVALID;
        ms_line_q[m]  <= '0;
        ms_btag_q[m]  <= 4'd0;
        ms_wait_q[m]  <= '0;
      end else begin
        ms_state_q[m] <= ms_state_d[m];
        ms_line_q[m]  <= ms_line_d[m];
        ms_btag_q[m]  <= ms_btag_d[m];
        ms_wait_q[m]  <= ms_wait_d[m];
      end
    end
  end

  // MSHR next state: allocate, issue, retire on fill.
  always_comb begin
    for (int m = 0; m < N_MSHR; m++) begin
      ms_state_d[m] = ms_state_q[m];
      ms_line_d[m]  = ms_line_q[m];
      ms_btag_d[m]  = ms_btag_q[m];
      ms_wait_d[m]  = ms_wait_q[m] | ms_add_s[m];
      case (ms_state_q[m])
        MS_INVALID: begin
          if (ms_new_s[m]) begin
            ms_state_d[m] = MS_PENDING;
            ms_line_d[m]  = ms_new_line_s[m];
            ms_wait_d[m]  = ms_add_s[m];
          end else begin
            ms_state_d[m] = MS_INVALID;
          end
        end
        MS_PENDING: begin
          if (ld_go_s && (ld_go_idx_s == MI_W'(m)) && (mem2dc_response != 4'd0)) begin
            ms_state_d[m] = MS_WAIT;
            ms_btag_d[m]  = mem2dc_response;
          end else begin
            ms_state_d[m] = MS_PENDING;
          end
        end
        MS_WAIT: begin
          if (fill_v_s && (fill_idx_s == MI_W'(m))) begin
            ms_state_d[m] = MS_INVALID;
            ms_wait_d[m]  = '0;
          end else begin
            ms_state_d[m] = MS_WAIT;
          end
        end
        default: ms_state_d[m] = MS_INVALID;
      endcase
    end
  end

  // Outputs: bus request, store completion and per-port load results.
  always_comb begin
    dc2mem_command = BUS_NONE;
    dc2mem_addr    = '0;
    dc2mem_data    = 64'd0;
    st_accepted    = 1'b0;
    ld_valid_out   = '0;
    ld_accepted    = '0;
    ld_data_out    = '0;
    if (reset) begin
      dc2mem_command = BUS_NONE;
    end else begin
      if (st_go_s) begin
        dc2mem_command = BUS_STORE;
        dc2mem_addr    = {st_addr[ADDR_W-1:3], 3'b000};
        dc2mem_data    = st_data;
        st_accepted    = (mem2dc_response != 4'd0);
      end else if (ld_go_s) begin
        dc2mem_command = BUS_LOAD;
        dc2mem_addr    = {ms_line_q[ld_go_idx_s], 3'b000};
      end else begin
        dc2mem_command = BUS_NONE;
      end
      ld_valid_out = ld_valid_s;
      ld_accepted  = ld_acc_s;
      for (int i = 0; i < N_LD; i++) begin
        ld_data_out[i*64 +: 64] = ld_rdata_s[i];
      end
    end
  end

  // Line valid bits: cleared on reset, set by a retiring fill.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int l = 0; l < N_LINES; l++) begin
        line_valid_q[l] <= 1'b0;
      end
    end else if (fill_v_s) begin
      line_valid_q[fill_line_s[IDX_W-1:0]] <= 1'b1;
    end else begin
      line_valid_q[0] <= line_valid_q[0];
    end
  end

  // Line tag/data: written by fills and by accepted stores that hit a resident line.
  always_ff @(posedge clock) begin
    if (!reset && fill_v_s) begin
      line_tag_q[fill_line_s[IDX_W-1:0]]  <= fill_line_s[LINE_W-1:IDX_W];
      line_data_q[fill_line_s[IDX_W-1:0]] <= mem2dc_data;
    end else if (!reset && st_upd_s) begin
      line_data_q[st_addr[IDX_W+2:3]] <= st_data;
    end else begin
      line_data_q[0] <= line_data_q[0];
    end
  end

  // Byte offsets are intentionally ignored.
  always_comb begin
    unused_s = ^st_addr[2:0];
    for (int i = 0; i < N_LD; i++) begin
      unused_s = unused_s ^ (^ld_addr[i*ADDR_W +: 3]);
    end
  end

endmodule
